gcd_request_sequencer: RTL and testbench
========================================

# gcd_request_sequencer

Front-end sequencer for the GCD core. Accepts operand pairs over a valid/ready request channel, loads them into the core, starts it, and watches its ready flag. It returns the result, the request tag and a timeout error flag over a valid/ready response channel. It serialises requests, so exactly one operation is in flight in the core at any time.

## Interface
Parameters:
- W, 16, operand/result width; must match the core.
- TAG_W, 4, request tag width.
- TIMEOUT, 70000, maximum RUN cycles before the operation is abandoned; must be ≥ 2^W + 4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_x, req_y  in  W each  operands.
- req_tag  in  TAG_W  opaque tag, returned with the result.
- core_xi, core_yi  out  W each  operand drive to the core.
- core_run  out  1  core control: 0 = load operands, 1 = compute.
- core_rdy  in  1  core done flag.
- core_xo  in  W  core result.
- res_valid  out  1  response present.
- res_ready  in  1  consumer accepts the response.
- res_gcd  out  W  result; 0 if either operand is 0 or on timeout.
- res_tag  out  TAG_W  tag of the completed request.
- res_err  out  1  operation timed out.
- busy  out  1  state ≠ IDLE.
- done_cnt  out  16  completed responses (wraps at 0xFFFF→0).
- err_cnt  out  8  timeouts; saturates at 0xFF.

## Operation
States:
- IDLE: req_ready=1, core_run=0. Handshake req_valid&req_ready → latch x/y/tag, clear timer, go to LOAD.
- LOAD: core_run=0 with latched operands on core_xi/yi for exactly 2 cycles (loads the core and clears core_rdy), then go to RUN.
- RUN: core_run=1, timer increments each cycle.
  - core_rdy=1 → capture core_xo into res_gcd, res_err=0, go to DONE.
  - Timer reaches TIMEOUT−1 with core_rdy=0 → res_gcd=0, res_err=1, err_cnt++, go to DONE.
  - core_rdy has priority when both events occur in the same cycle.
- DONE: res_valid=1, core_run=0. res_valid&res_ready → done_cnt++, go to IDLE.

Rules:
- core_rdy is sampled only in RUN and ignored in every other state.
- core_xi/yi hold the latched operands from LOAD until the next accept.
- res_gcd/tag/err are stable while res_valid=1 and res_ready=0.
- req_ready=1 only in IDLE: there is no request overlap and no bypass.
- Operands of 0 are passed to the core unchanged. The core reports 0; the sequencer does not special-case them.
- Reset mid-operation discards the in-flight request without emitting a response. Reset forces core_run=0.

## Timing
- Reset values: req_ready=0 during reset and 1 in the first cycle after reset. res_valid=0, res_gcd=0, res_tag=0, res_err=0, core_run=0, core_xi=0, core_yi=0, busy=0, done_cnt=0, err_cnt=0, state=IDLE.
- Accept at edge N:
  - LOAD occupies cycles N+1 and N+2.
  - RUN starts at N+3.
  - res_valid rises one cycle after core_rdy is seen in RUN.
- Minimum turnaround (zero operand, core_rdy at first RUN edge): accept→res_valid = 5 cycles. Back-to-back accept at the earliest 1 cycle after the response handshake.
- All outputs are registered. There is no combinational path from req_valid or res_ready to any output.

## Structure
- Package gcd_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - localparams LOAD_CYCLES=2 and TIMER_W=$clog2(TIMEOUT+1);
  - a response struct {gcd, tag, err}.
- One module with no sub-module. The timer is an inline TIMER_W counter.
- The core is instantiated next to this block by the parent, not inside it.

## Test plan
- Basic: req (48,18,tag 3) → core_run low 2 cycles then high; res_valid with res_gcd=6, res_tag=3, res_err=0; done_cnt=1.
- Zero operand: req (0,25) → res_gcd=0, res_err=0, res_valid 5 cycles after accept.
- Backpressure: res_ready held 0 for 10 cycles after (35,21) completes → res_gcd=7 stable, req_ready=0 throughout; release → IDLE next cycle.
- Timeout: TIMEOUT=20, core model never asserts core_rdy → res_valid at RUN cycle 20 with res_err=1, res_gcd=0; err_cnt=1.
- Race: core_rdy and timeout expiry in the same cycle → res_err=0 and core result returned.
- Reset mid-RUN: (65535,1) accepted, rst=0 after 10 RUN cycles → no response, all outputs at reset values; next req (12,8) → res_gcd=4.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD request sequencer: FSM states,
// load-phase length, timer sizing and the response record.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int GCD_W       = 16;
    localparam int GCD_TAG_W   = 4;
    localparam int TIMEOUT_DEF = 70000;
    localparam int LOAD_CYCLES = 2;
    localparam int TIMER_W     = $clog2(TIMEOUT_DEF + 1);

    typedef struct packed {
        logic [GCD_W-1:0]     gcd;
        logic [GCD_TAG_W-1:0] tag;
        logic                 err;
    } resp_t;

    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/gcd_request_sequencer.sv
// Serialising front end for the GCD core: takes one request, loads and runs
// the core, and returns result/tag/timeout flag over a response handshake.
module gcd_request_sequencer
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int TAG_W   = GCD_TAG_W,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_x,
    input  logic [W-1:0]     req_y,
    input  logic [TAG_W-1:0] req_tag,
    output logic [W-1:0]     core_xi,
    output logic [W-1:0]     core_yi,
    output logic             core_run,
    input  logic             core_rdy,
    input  logic [W-1:0]     core_xo,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_gcd,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy,
    output logic [15:0]      done_cnt,
    output logic [7:0]       err_cnt
);

    localparam int TMR_W = timer_width(TIMEOUT);

    state_e             state_q;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;
    logic               timeout_hit;
    logic [1:0]         load_q;
    logic [W-1:0]       xi_q;
    logic [W-1:0]       yi_q;
    logic [TAG_W-1:0]   tag_q;
    resp_t              res_q;
    logic               req_ready_q;
    logic               core_run_q;
    logic               res_valid_q;
    logic               busy_q;
    logic [15:0]        done_cnt_q;
    logic [7:0]         err_cnt_q;

    always_comb begin
        timer_d     = timer_q + 1'b1;
        timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));
    end

    // All outputs are registered and updated together with the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            load_q      <= '0;
            xi_q        <= '0;
            yi_q        <= '0;
            tag_q       <= '0;
            res_q       <= '0;
            req_ready_q <= 1'b0;
            core_run_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        xi_q        <= req_x;
                        yi_q        <= req_y;
                        tag_q       <= req_tag;
                        timer_q     <= '0;
                        load_q      <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    // Holding core_run low for the whole load phase also clears core_rdy.
                    if (load_q == 2'(LOAD_CYCLES - 1)) begin
                        core_run_q <= 1'b1;
                        state_q    <= RUN;
                    end else begin
                        load_q <= load_q + 1'b1;
                    end
                end
                RUN: begin
                    if (core_rdy) begin
                        res_q.gcd   <= core_xo;
                        res_q.tag   <= tag_q;
                        res_q.err   <= 1'b0;
                        core_run_q  <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (timeout_hit) begin
                        res_q.gcd   <= '0;
                        res_q.tag   <= tag_q;
                        res_q.err   <= 1'b1;
                        core_run_q  <= 1'b0;
                        res_valid_q <= 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        done_cnt_q  <= done_cnt_q + 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign core_xi   = xi_q;
    assign core_yi   = yi_q;
    assign core_run  = core_run_q;
    assign res_valid = res_valid_q;
    assign res_gcd   = res_q.gcd;
    assign res_tag   = res_q.tag;
    assign res_err   = res_q.err;
    assign busy      = busy_q;
    assign done_cnt  = done_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gcd_request_sequencer.sv
// Directed bench for gcd_request_sequencer with a latency-programmable
// behavioural GCD core attached to the core-side ports.
module tb_gcd_request_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_x = '0;
    logic [15:0] req_y = '0;
    logic [3:0]  req_tag = '0;
    logic [15:0] core_xi;
    logic [15:0] core_yi;
    logic        core_run;
    logic        core_rdy = 1'b0;
    logic [15:0] core_xo = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_gcd;
    logic [3:0]  res_tag;
    logic        res_err;
    logic        busy;
    logic [15:0] done_cnt;
    logic [7:0]  err_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Core model: asserts core_rdy on its core_lat-th compute edge; 0 means never.
    int          core_lat = 1;
    int          crun_cnt = 0;
    logic [15:0] cx = '0;
    logic [15:0] cy = '0;

    always #5 clk = ~clk;

    gcd_request_sequencer #(
        .W(16),
        .TAG_W(4),
        .TIMEOUT(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_x(req_x),
        .req_y(req_y),
        .req_tag(req_tag),
        .core_xi(core_xi),
        .core_yi(core_yi),
        .core_run(core_run),
        .core_rdy(core_rdy),
        .core_xo(core_xo),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_gcd(res_gcd),
        .res_tag(res_tag),
        .res_err(res_err),
        .busy(busy),
        .done_cnt(done_cnt),
        .err_cnt(err_cnt)
    );

    function automatic logic [15:0] ref_gcd(input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] t;
        a = a_in;
        b = b_in;
        if (a == 0 || b == 0) return 16'd0;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge clk) begin
        if (!core_run) begin
            cx       <= core_xi;
            cy       <= core_yi;
            core_rdy <= 1'b0;
            crun_cnt <= 0;
        end else begin
            crun_cnt <= crun_cnt + 1;
            if (core_lat != 0 && crun_cnt + 1 == core_lat) begin
                core_rdy <= 1'b1;
                core_xo  <= ref_gcd(cx, cy);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accept edge.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [3:0] tag);
        logic acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        req_tag   = tag;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = req_ready;
            tick();
        end
        req_valid = 1'b0;
        check("req_accepted", {31'd0, acc}, 32'd1);
    endtask

    // cyc counts the accept edge as 1; runs counts cycles with core_run high.
    task automatic wait_resp(input int max, output int cyc, output int runs);
        cyc  = 1;
        runs = 0;
        while (!res_valid && cyc < max) begin
            if (core_run) runs++;
            tick();
            cyc++;
        end
        check("res_valid_seen", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic ack();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int runs;
        int guard;

        // Reset
        rst = 1'b0;
        tick();
        tick();
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_outs", {res_valid, res_err, core_run, busy, res_tag, res_gcd}, 32'd0);
        check("rst_core_xy", {core_xi, core_yi}, 32'd0);
        check("rst_cnts", {8'd0, done_cnt, err_cnt}, 32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Basic: 48,18 tag 3
        core_lat = 5;
        send(16'd48, 16'd18, 4'd3);
        check("basic_load1_run", {31'd0, core_run}, 32'd0);
        check("basic_busy", {31'd0, busy}, 32'd1);
        tick();
        check("basic_load2_run", {31'd0, core_run}, 32'd0);
        tick();
        check("basic_run_high", {31'd0, core_run}, 32'd1);
        wait_resp(100, cyc, runs);
        check("basic_gcd", {16'd0, res_gcd}, 32'd6);
        check("basic_tag", {28'd0, res_tag}, 32'd3);
        check("basic_err", {31'd0, res_err}, 32'd0);
        check("basic_run_low_done", {31'd0, core_run}, 32'd0);
        ack();
        check("basic_done_cnt", {16'd0, done_cnt}, 32'd1);
        check("basic_idle_ready", {31'd0, req_ready}, 32'd1);
        check("basic_idle_valid", {31'd0, res_valid}, 32'd0);

        // Zero operand, minimum turnaround
        core_lat = 1;
        send(16'd0, 16'd25, 4'd5);
        wait_resp(100, cyc, runs);
        check("zero_latency", cyc, 32'd5);
        check("zero_gcd", {16'd0, res_gcd}, 32'd0);
        check("zero_err", {31'd0, res_err}, 32'd0);
        ack();
        check("zero_done_cnt", {16'd0, done_cnt}, 32'd2);
        check("zero_core_yi_held", {16'd0, core_yi}, 32'd25);

        // Backpressure: 35,21 held for 10 cycles
        core_lat = 3;
        send(16'd35, 16'd21, 4'd9);
        wait_resp(100, cyc, runs);
        for (int i = 0; i < 10; i++) begin
            check("bp_gcd", {16'd0, res_gcd}, 32'd7);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        check("bp_valid_held", {31'd0, res_valid}, 32'd1);
        check("bp_tag", {28'd0, res_tag}, 32'd9);
        ack();
        check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
        check("bp_idle_busy", {31'd0, busy}, 32'd0);
        check("bp_done_cnt", {16'd0, done_cnt}, 32'd3);

        // Timeout: core never finishes
        core_lat = 0;
        send(16'd100, 16'd75, 4'd2);
        wait_resp(100, cyc, runs);
        check("to_run_cycles", runs, 32'd20);
        check("to_err", {31'd0, res_err}, 32'd1);
        check("to_gcd", {16'd0, res_gcd}, 32'd0);
        check("to_tag", {28'd0, res_tag}, 32'd2);
        check("to_err_cnt", {24'd0, err_cnt}, 32'd1);
        ack();
        check("to_done_cnt", {16'd0, done_cnt}, 32'd4);

        // Race: core_rdy seen on the same edge the timer expires
        core_lat = 19;
        send(16'd84, 16'd36, 4'd6);
        wait_resp(100, cyc, runs);
        check("race_run_cycles", runs, 32'd20);
        check("race_err", {31'd0, res_err}, 32'd0);
        check("race_gcd", {16'd0, res_gcd}, 32'd12);
        check("race_err_cnt", {24'd0, err_cnt}, 32'd1);
        ack();
        check("race_done_cnt", {16'd0, done_cnt}, 32'd5);

        // Reset after 10 RUN cycles
        core_lat = 0;
        send(16'hFFFF, 16'd1, 4'd7);
        runs  = 0;
        guard = 0;
        while (runs < 10 && guard < 40) begin
            tick();
            guard++;
            if (core_run) runs++;
        end
        check("mid_run_reached", runs, 32'd10);
        rst = 1'b0;
        tick();
        check("mid_rst_outs", {res_valid, res_err, core_run, busy, res_tag, res_gcd}, 32'd0);
        check("mid_rst_core_xy", {core_xi, core_yi}, 32'd0);
        check("mid_rst_cnts", {8'd0, done_cnt, err_cnt}, 32'd0);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("mid_post_rst_ready", {31'd0, req_ready}, 32'd1);
        guard = 0;
        for (int i = 0; i < 25; i++) begin
            if (res_valid) guard++;
            tick();
        end
        check("mid_no_response", guard, 32'd0);

        core_lat = 4;
        send(16'd12, 16'd8, 4'd1);
        wait_resp(100, cyc, runs);
        check("after_rst_gcd", {16'd0, res_gcd}, 32'd4);
        check("after_rst_tag", {28'd0, res_tag}, 32'd1);
        check("after_rst_err", {31'd0, res_err}, 32'd0);
        ack();
        check("after_rst_done_cnt", {16'd0, done_cnt}, 32'd1);
        check("after_rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
